// File: rtl/revaluate_controller.sv
// Top-level sequencer for the revaluate flow: reads each file, loads the state,
// runs NUM_ROUNDS permutation rounds, hands the result to the writer, then signals done.
module revaluate_controller #(
  parameter int unsigned NUM_FILES  = 4,
  parameter int unsigned NUM_ROUNDS = 24,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned RND_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             wr_ready,
  output logic             read_file,
  output logic [IDX_W-1:0] file_index,
  output logic             ld_state,
  output logic             round_en,
  output logic [RND_W-1:0] round_idx,
  output logic             write_file,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_ROUND,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W-1:0] LAST_FILE = IDX_W'(NUM_FILES - 1);

  state_t state, state_nx;
  logic   abort_run;

  assign abort_run = abort && (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (abort_run) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start && !abort) state_nx = S_READ;
        S_READ:  state_nx = S_LOAD;
        S_LOAD:  state_nx = S_ROUND;
        S_ROUND: if (round_idx == LAST_RND) state_nx = S_WRITE;
        S_WRITE: if (wr_ready) state_nx = S_NEXT;
        S_NEXT:  state_nx = (file_index == LAST_FILE) ? S_DONE : S_READ;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Abort clears the round counter but deliberately keeps file_index for inspection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      file_index <= '0;
      round_idx  <= '0;
    end else if (abort_run) begin
      round_idx <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start && !abort) file_index <= '0;
        S_LOAD:  round_idx <= '0;
        S_ROUND: if (round_idx != LAST_RND) round_idx <= round_idx + RND_W'(1);
        S_NEXT:  if (file_index != LAST_FILE) file_index <= file_index + IDX_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    read_file  = 1'b0;
    ld_state   = 1'b0;
    round_en   = 1'b0;
    write_file = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_READ:  read_file  = 1'b1;
      S_LOAD:  ld_state   = 1'b1;
      S_ROUND: round_en   = 1'b1;
      S_WRITE: write_file = 1'b1;
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_revaluate_controller.sv
// Self-checking bench for revaluate_controller: builds the expected per-cycle output
// trace of a run from the flow rules and compares the DUT against it cycle by cycle.
module tb_revaluate_controller;

  localparam int NF = 4;
  localparam int NR = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       wr_ready = 1'b1;
  logic       read_file, ld_state, round_en, write_file, busy, done;
  logic [9:0] file_index;
  logic [4:0] round_idx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rf, ld, re, wf, dn;
    logic [9:0] fi;
    logic [4:0] ri;
    logic       wr;
  } exp_t;

  exp_t tr[$];
  int   stalls[NF];
  int   n_round, n_write, done_at;
  bit   done_seen;

  revaluate_controller #(
    .NUM_FILES (NF),
    .NUM_ROUNDS(NR),
    .IDX_W     (10),
    .RND_W     (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .wr_ready  (wr_ready),
    .read_file (read_file),
    .file_index(file_index),
    .ld_state  (ld_state),
    .round_en  (round_en),
    .round_idx (round_idx),
    .write_file(write_file),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic push(input logic rf, ld, re, wf, dn, input int fi, ri, input logic wr);
    exp_t e;
    e.rf = rf; e.ld = ld; e.re = re; e.wf = wf; e.dn = dn;
    e.fi = 10'(fi); e.ri = 5'(ri); e.wr = wr;
    tr.push_back(e);
  endtask

  // Each file: read, load, NR rounds, write (plus stall cycles), next; then one done cycle.
  task automatic build_trace();
    tr.delete();
    for (int f = 0; f < NF; f++) begin
      push(1, 0, 0, 0, 0, f, 0, 1'($urandom_range(0, 1)));
      push(0, 1, 0, 0, 0, f, 0, 1'($urandom_range(0, 1)));
      for (int r = 0; r < NR; r++) push(0, 0, 1, 0, 0, f, r, 1'($urandom_range(0, 1)));
      for (int s = 0; s < stalls[f]; s++) push(0, 0, 0, 1, 0, f, 0, 1'b0);
      push(0, 0, 0, 1, 0, f, 0, 1'b1);
      push(0, 0, 0, 0, 0, f, 0, 1'($urandom_range(0, 1)));
    end
    push(0, 0, 0, 0, 1, NF - 1, 0, 1'($urandom_range(0, 1)));
  endtask

  task automatic run_trace(input int abort_at, input bit rand_start);
    logic [15:0] obs, exp_v;
    n_round = 0; n_write = 0; done_at = -1; done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      obs   = {read_file, ld_state, round_en, write_file, busy, done, file_index};
      exp_v = {tr[i].rf, tr[i].ld, tr[i].re, tr[i].wf, 1'b1, tr[i].dn, tr[i].fi};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL trace cycle %0d: got %h expected %h", i + 1, obs, exp_v);
      end
      if (tr[i].re) begin
        checks++;
        if (round_idx !== tr[i].ri) begin
          failures++;
          $display("FAIL round_idx cycle %0d: got %0d expected %0d", i + 1, round_idx, tr[i].ri);
        end
      end
      if (round_en) n_round++;
      if (write_file) n_write++;
      if (done) begin done_seen = 1; done_at = i + 1; end
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        obs   = {read_file, ld_state, round_en, write_file, busy, done, file_index};
        exp_v = {6'b0, tr[i].fi};
        checks++;
        if (obs !== exp_v || round_idx !== 5'd0) begin
          failures++;
          $display("FAIL abort_idle: got %h ridx %0d expected %h ridx 0", obs, round_idx, exp_v);
        end
        return;
      end
      wr_ready = tr[i].wr;
      if (rand_start) start = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; wr_ready = 1'b1;
    obs = {read_file, ld_state, round_en, write_file, busy, done, file_index};
    exp_v = {6'b0, 10'(NF - 1)};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL post_run_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    #1;
    obs = {read_file, ld_state, round_en, write_file, busy, done, file_index, round_idx};
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL reset_initial: got %h expected 0", obs);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (round_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_round: got round_en %b busy %b expected 1 1", round_en, busy);
    end
    #2 rst = 1'b0;
    #1;
    obs = {read_file, ld_state, round_en, write_file, busy, done, file_index, round_idx};
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL reset_async: got %h expected 0", obs);
    end
    repeat (3) @(posedge clk);
    #1;
    obs = {read_file, ld_state, round_en, write_file, busy, done, file_index, round_idx};
    checks++;
    if (obs !== 21'd0) begin
      failures++;
      $display("FAIL reset_held: got %h expected 0", obs);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_default_run();
    for (int f = 0; f < NF; f++) stalls[f] = 0;
    build_trace();
    run_trace(-1, 1'b0);
    checks++;
    if (n_round != NF * NR) begin
      failures++;
      $display("FAIL default_round_count: got %0d expected %0d", n_round, NF * NR);
    end
    checks++;
    if (done_at != 28 * NF + 1) begin
      failures++;
      $display("FAIL default_done_cycle: got %0d expected %0d", done_at, 28 * NF + 1);
    end
  endtask

  task automatic test_backpressure();
    for (int f = 0; f < NF; f++) stalls[f] = 0;
    stalls[0] = 5;
    build_trace();
    run_trace(-1, 1'b0);
    checks++;
    if (n_write != 6 + (NF - 1)) begin
      failures++;
      $display("FAIL bp_write_cycles: got %0d expected %0d", n_write, 6 + NF - 1);
    end
    checks++;
    if (done_at != 28 * NF + 1 + 5) begin
      failures++;
      $display("FAIL bp_done_cycle: got %0d expected %0d", done_at, 28 * NF + 6);
    end
  endtask

  task automatic test_abort();
    for (int f = 0; f < NF; f++) stalls[f] = 0;
    build_trace();
    run_trace(2 + 10, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    checks++;
    if (done_seen || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: got done_seen %0b busy %b expected 0 0", done_seen, busy);
    end
    build_trace();
    run_trace(-1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      for (int f = 0; f < NF; f++) stalls[f] = $urandom_range(0, 4);
      build_trace();
      run_trace(-1, 1'b1);
    end
  endtask

  task automatic test_ignored();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || read_file !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_idle: got busy %b read_file %b expected 0 0", busy, read_file);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || file_index !== 10'(NF - 1)) begin
      failures++;
      $display("FAIL abort_in_idle: got busy %b fi %0d expected 0 %0d", busy, file_index, NF - 1);
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_backpressure();
    test_abort();
    test_random();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/revaluate_controller.md
Name: revaluate_controller

Overview:
- Top-level sequencing FSM for the revaluate flow.
- For each input file index it drives the file reader (read_file/file_index), loads the 1600-bit state into the permutation datapath, and steps the round datapath through NUM_ROUNDS rounds.
- It then hands the result to the output writer with a ready handshake and advances to the next file.
- It reports busy/done to the testbench or host.

Parameters:
- NUM_FILES, 4, number of files processed per run; indices 0..NUM_FILES-1.
- NUM_ROUNDS, 24, permutation rounds per file.
- IDX_W, 10, width of file_index.
- RND_W, 5, width of round_idx; must satisfy 2^RND_W >= NUM_ROUNDS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state, no done pulse.
- wr_ready  input  1  output writer accepts the current result.
- read_file  output  1  one-cycle request to the file reader.
- file_index  output  IDX_W  index of the file being processed.
- ld_state  output  1  load the reader's data_out into the state register.
- round_en  output  1  advance the round datapath by one round.
- round_idx  output  RND_W  current round number (round-constant select).
- write_file  output  1  result valid for the writer; held until wr_ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of a complete run.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, file_index=0, round_idx=0, all control outputs 0.
- All outputs are Moore-decoded from state and registered counters; no combinational path from any input to any output.
- State transitions:
  - IDLE: start=1 -> READ, file_index<=0. start while busy is ignored.
  - READ: read_file=1 for exactly one cycle -> LOAD. The reader updates its memory on this edge.
  - LOAD: ld_state=1 for one cycle -> ROUND, round_idx<=0.
  - ROUND: round_en=1 every cycle. If round_idx==NUM_ROUNDS-1 -> WRITE; else round_idx+1. round_idx never exceeds NUM_ROUNDS-1.
  - WRITE: write_file=1 held while wr_ready=0. wr_ready=1 sampled -> NEXT. Exactly one transfer per file.
  - NEXT: if file_index==NUM_FILES-1 -> DONE; else file_index+1 -> READ.
  - DONE: done=1 for one cycle -> IDLE. file_index keeps its last value until the next start.
- abort=1 in any non-IDLE state: next state IDLE; round_idx cleared; file_index held; no done. abort has priority over every other transition. abort in IDLE has no effect.
- start and abort both high in IDLE: stay IDLE.
- Latency per file with wr_ready tied high: 28 cycles (READ 1 + LOAD 1 + ROUND 24 + WRITE 1 + NEXT 1).
- Total run length: start edge to done = 28*NUM_FILES + 1 cycles.
- Each extra cycle with wr_ready low extends WRITE by one cycle.
- Reset mid-run: immediate return to the reset values, including deassertion of write_file and round_en.

Test Plan:
- Reset check: rst=0 for 3 cycles mid-ROUND -> all outputs 0, file_index=0, busy=0 immediately (asynchronous, before the next clock edge).
- Single file (NUM_FILES=1, wr_ready=1): start pulse accepted at edge 0, with cycles numbered by the state held after each edge ->
  - read_file high in cycle 1
  - ld_state in cycle 2
  - round_en cycles 3..26 with round_idx 0..23
  - write_file cycle 27
  - done cycle 29
  - busy low from cycle 30
- Default run (NUM_FILES=4, wr_ready=1) -> read_file pulses with file_index 0,1,2,3 at cycles 1,29,57,85; done at cycle 113; exactly 96 round_en cycles.
- Backpressure: wr_ready low for 5 cycles at the first WRITE -> write_file held 6 cycles; every later event shifted by 5; still one transfer per file.
- Abort during ROUND (round_idx=10) -> IDLE next cycle, round_idx=0, no done; a new start restarts from file_index=0.
- Ignored inputs: start pulse while busy -> no effect; start and abort together in IDLE -> stays IDLE.
